// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (pixel/line counters, sync pulses,
// active-video and start-of-line/frame flags). Defaults give 1280x720 @ 60 Hz
// with a 74.25 MHz pixel clock.
//
// Optional feature macro: VGA_SYNC_POS_EN
//   defined   -> h_sync / v_sync are active-high (inactive level 0)
//   undefined -> h_sync / v_sync are active-low  (inactive level 1)
//
// Handshake: pix_en is a plain qualifier, not a valid/ready pair. On a clock
// edge with pix_en=1 the raster advances one pixel; with pix_en=0 every
// register (counters, FSM states and flags) holds its value.
//
// All outputs are registered and computed from the *next* counter values, so
// every flag is aligned with the counter values presented on the same cycle.

module vga_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FRONT  = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [11:0] h_counter,
    output logic [11:0] v_counter,
    output logic        h_sync,
    output logic        v_sync,
    output logic        active,
    output logic        line_start,
    output logic        frame_start
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Counters are 12 bits wide, so the raster must fit in 4096x4096.
    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
            $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
        end
    endgenerate

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_FP_START = 12'(H_ACTIVE);
    localparam logic [11:0] H_SY_START = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_BP_START = 12'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_FP_START = 12'(V_ACTIVE);
    localparam logic [11:0] V_SY_START = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_BP_START = 12'(V_ACTIVE + V_FRONT + V_SYNC);

`ifdef VGA_SYNC_POS_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif
    localparam logic SYNC_OFF = ~SYNC_ON;

    // ------------------------------------------------------------------
    // Horizontal / vertical region state machines
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        H_ACT = 2'd0,
        H_FP  = 2'd1,
        H_SY  = 2'd2,
        H_BP  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACT = 2'd0,
        V_FP  = 2'd1,
        V_SY  = 2'd2,
        V_BP  = 2'd3
    } v_state_t;

    // Region decode of a column; the FSM state is always the decode of the
    // registered counter, so the two can never disagree.
    function automatic h_state_t h_decode(input logic [11:0] h);
        if (h < H_FP_START)      return H_ACT;
        else if (h < H_SY_START) return H_FP;
        else if (h < H_BP_START) return H_SY;
        else                     return H_BP;
    endfunction

    function automatic v_state_t v_decode(input logic [11:0] v);
        if (v < V_FP_START)      return V_ACT;
        else if (v < V_SY_START) return V_FP;
        else if (v < V_BP_START) return V_SY;
        else                     return V_BP;
    endfunction

    h_state_t    h_state, h_state_next;
    v_state_t    v_state, v_state_next;
    logic [11:0] h_next, v_next;
    logic        h_sync_next, v_sync_next;
    logic        active_next, line_start_next, frame_start_next;

    // Counter advance: column wraps at H_LAST and carries into the line count.
    always_comb begin
        h_next = h_counter;
        v_next = v_counter;
        if (pix_en) begin
            if (h_counter == H_LAST) begin
                h_next = 12'd0;
                if (v_counter == V_LAST) v_next = 12'd0;
                else                     v_next = v_counter + 12'd1;
            end else begin
                h_next = h_counter + 12'd1;
            end
        end
    end

    // FSM next-state: regions follow the next counter values.
    always_comb begin
        h_state_next = h_state;
        v_state_next = v_state;
        if (pix_en) begin
            h_state_next = h_decode(h_next);
            v_state_next = v_decode(v_next);
        end
    end

    // Output flags derived from the next FSM states / counters.
    always_comb begin
        h_sync_next      = SYNC_OFF;
        v_sync_next      = SYNC_OFF;
        active_next      = 1'b0;
        line_start_next  = 1'b0;
        frame_start_next = 1'b0;
        if (h_state_next == H_SY) h_sync_next = SYNC_ON;
        if (v_state_next == V_SY) v_sync_next = SYNC_ON;
        active_next      = (h_state_next == H_ACT) && (v_state_next == V_ACT);
        line_start_next  = (h_next == 12'd0);
        frame_start_next = (h_next == 12'd0) && (v_next == 12'd0);
    end

    // FSM state registers; reset parks the raster on the last pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state <= H_BP;
            v_state <= V_BP;
        end else if (pix_en) begin
            h_state <= h_state_next;
            v_state <= v_state_next;
        end
    end

    // Counter and flag registers; everything holds while pix_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_counter   <= H_LAST;
            v_counter   <= V_LAST;
            h_sync      <= SYNC_OFF;
            v_sync      <= SYNC_OFF;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            h_counter   <= h_next;
            v_counter   <= v_next;
            h_sync      <= h_sync_next;
            v_sync      <= v_sync_next;
            active      <= active_next;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance with the 720p defaults (line-level
// checks) and one with a reduced raster so whole frames fit in a short run.

module tb_vga_timing_gen;

    // reduced raster: H 16/4/3/5 = 28, V 6/2/2/3 = 13, frame = 364 pixels
    localparam int S_HA = 16, S_HF = 4, S_HS = 3, S_HB = 5;
    localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = 28, S_VT = 13;
    localparam int D_HT = 1650, D_VT = 750;

`ifdef VGA_SYNC_POS_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    logic [11:0] s_h, s_v, d_h, d_v;
    logic        s_hs, s_vs, s_act, s_ls, s_fs;
    logic        d_hs, d_vs, d_act, d_ls, d_fs;

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(s_h), .v_counter(s_v), .h_sync(s_hs), .v_sync(s_vs),
        .active(s_act), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(d_h), .v_counter(d_v), .h_sync(d_hs), .v_sync(d_vs),
        .active(d_act), .line_start(d_ls), .frame_start(d_fs)
    );

    // vector layout: {h[11:0], v[11:0], h_sync, v_sync, active, line_start, frame_start}
    logic [28:0] s_vec, d_vec;
    assign s_vec = {s_h, s_v, s_hs, s_vs, s_act, s_ls, s_fs};
    assign d_vec = {d_h, d_v, d_hs, d_vs, d_act, d_ls, d_fs};

    // ---------------- reference model ----------------
    int m_sh, m_sv, m_dh, m_dv;

    function automatic logic [28:0] model_out(input int h, input int v,
                                              input int ha, input int hf, input int hs,
                                              input int va, input int vf, input int vs);
        logic hs_on, vs_on, act, ls, fs;
        hs_on = (h >= ha + hf) && (h < ha + hf + hs);
        vs_on = (v >= va + vf) && (v < va + vf + vs);
        act   = (h < ha) && (v < va);
        ls    = (h == 0);
        fs    = (h == 0) && (v == 0);
        return {12'(h), 12'(v), hs_on ? SYNC_ON : ~SYNC_ON,
                vs_on ? SYNC_ON : ~SYNC_ON, act, ls, fs};
    endfunction

    function automatic logic [28:0] mk_vec(input int h, input int v, input logic hs_on,
                                           input logic vs_on, input logic act,
                                           input logic ls, input logic fs);
        return {12'(h), 12'(v), hs_on ? SYNC_ON : ~SYNC_ON,
                vs_on ? SYNC_ON : ~SYNC_ON, act, ls, fs};
    endfunction

    // ---------------- scoreboard ----------------
    logic [28:0] exp_s_q[$];
    logic [28:0] exp_d_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles = 0;

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got h=%0d v=%0d hs/vs/act/ls/fs=%b, expected h=%0d v=%0d hs/vs/act/ls/fs=%b",
                     name, act[28:17], act[16:5], act[4:0], exp[28:17], exp[16:5], exp[4:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sh = S_HT - 1; m_sv = S_VT - 1;
        m_dh = D_HT - 1; m_dv = D_VT - 1;
        exp_s_q.delete();
        exp_d_q.delete();
    endtask

    task automatic model_adv(inout int h, inout int v, input int ht, input int vt);
        if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    // Driver: called #1 after a rising edge; drives pix_en, pushes the
    // expected outputs, waits for the edge, then pops and compares.
    task automatic step(input logic en);
        pix_en = en;
        if (en) begin
            model_adv(m_sh, m_sv, S_HT, S_VT);
            model_adv(m_dh, m_dv, D_HT, D_VT);
            en_cycles++;
        end
        exp_s_q.push_back(model_out(m_sh, m_sv, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS));
        exp_d_q.push_back(model_out(m_dh, m_dv, 1280, 110, 40, 720, 5, 5));
        @(posedge clk);
        #1;
        check("sb_small", s_vec, exp_s_q.pop_front());
        check("sb_default", d_vec, exp_d_q.pop_front());
    endtask

    // ---------------- directed table for the default raster ----------------
    typedef struct {
        int   n;
        logic en;
        int   h;
        int   v;
        logic act;
        logic hs_on;
        logic ls;
        logic fs;
    } vec_rec_t;

    vec_rec_t tbl[12];

    // ---------------- test sequence ----------------
    initial begin
        int hs_cnt, act_cnt, ls_cnt;
        int edges, last_edge, guard;
        logic prev_vs;

        tbl[0]  = '{1,    1'b1, 0,    0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{10,   1'b0, 0,    0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1,    1'b1, 1,    0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1278, 1'b1, 1279, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1,    1'b1, 1280, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{109,  1'b1, 1389, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1,    1'b1, 1390, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{39,   1'b1, 1429, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1,    1'b1, 1430, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{219,  1'b1, 1649, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1,    1'b1, 0,    1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{3,    1'b0, 0,    1, 1'b1, 1'b0, 1'b1, 1'b0};

        // reset from time zero
        rst    = 1'b1;
        pix_en = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_small",   s_vec, mk_vec(27,   12,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("reset_default", d_vec, mk_vec(1649, 749, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;

        // table-driven walk through the first line of the default raster
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].en);
            check($sformatf("tbl_%0d", i), d_vec,
                  mk_vec(tbl[i].h, tbl[i].v, tbl[i].hs_on, 1'b0,
                         tbl[i].act, tbl[i].ls, tbl[i].fs));
        end

        // one full default line: 40 sync cycles, 1280 active, 1 line start
        hs_cnt = 0; act_cnt = 0; ls_cnt = 0;
        for (int k = 0; k < D_HT; k++) begin
            step(1'b1);
            if (d_hs == SYNC_ON) hs_cnt++;
            if (d_act) act_cnt++;
            if (d_ls) ls_cnt++;
        end
        check_int("line_hsync_cycles", hs_cnt, 40);
        check_int("line_active_cycles", act_cnt, 1280);
        check_int("line_start_count", ls_cnt, 1);

        // reduced raster: v_sync rising-edge spacing with random pix_en gaps
        edges = 0; last_edge = 0; guard = 0;
        prev_vs = s_vs;
        while (edges < 3 && guard < 4000) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            guard++;
            if (prev_vs != SYNC_ON && s_vs == SYNC_ON) begin
                check("vsync_rise_pos", s_vec, mk_vec(0, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
                if (edges > 0) check_int("vsync_period", en_cycles - last_edge, S_HT * S_VT);
                last_edge = en_cycles;
                edges++;
            end
            prev_vs = s_vs;
        end
        check_int("vsync_edges_seen", edges, 3);

        // move the reduced raster into both sync windows (h=21, v=9)
        guard = 0;
        while (!(m_sh == 21 && m_sv == 9) && guard < 1000) begin
            step(1'b1);
            guard++;
        end
        check("pre_reset_pos", s_vec, mk_vec(21, 9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

        // asynchronous reset mid-clock, checked before the next edge
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset_small",   s_vec, mk_vec(27,   12,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("async_reset_default", d_vec, mk_vec(1649, 749, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_held_small", s_vec, mk_vec(27, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;

        // restart from 0,0 after release
        step(1'b1);
        check("restart_small",   s_vec, mk_vec(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        check("restart_default", d_vec, mk_vec(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        for (int k = 0; k < 40; k++) step(1'b1);
        check("restart_line2_small", s_vec, mk_vec(12, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator that produces the pixel/line counters, sync pulses and active-video flag consumed by vga_pixel_gen. It sits directly upstream of the pixel generator and drives its h_counter, v_counter and v_sync inputs. It also drives the board's VGA sync pins. Defaults are 1280x720 @ 60 Hz (74.25 MHz pixel clock), matching H_ACTIVE_PIXEL_COUNT and V_ACTIVE_LINE_COUNT in vga_parameters.svh.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FRONT, 110, horizontal front porch (pixels)
H_SYNC, 40, horizontal sync width (pixels)
H_BACK, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FRONT, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BACK, 20, vertical back porch (lines)

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous reset, active-high
pix_en  input  1  pixel-advance enable; all state holds when 0
h_counter  output  12  current pixel column, 0..H_TOTAL-1
v_counter  output  12  current line, 0..V_TOTAL-1
h_sync  output  1  horizontal sync, polarity per VGA_SYNC_POS_EN
v_sync  output  1  vertical sync, polarity per VGA_SYNC_POS_EN
active  output  1  1 when h_counter < H_ACTIVE and v_counter < V_ACTIVE
line_start  output  1  1 while h_counter == 0
frame_start  output  1  1 while h_counter == 0 and v_counter == 0

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (1650); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (750).
- Elaboration check: H_TOTAL and V_TOTAL must each be ≤ 4096. Violation is a fatal elaboration error.
- All outputs are registered. Each flag is computed from the next counter values, so every flag is cycle-aligned with the counter values output on the same cycle. Flags have zero latency relative to the counters.
- Reset (asynchronous, while rst=1):
  - h_counter = H_TOTAL-1 (1649) and v_counter = V_TOTAL-1 (749), i.e. the last pixel of a frame.
  - active=0, line_start=0, frame_start=0.
  - h_sync and v_sync at their inactive level.
- First clk edge with rst=0 and pix_en=1: counters become 0,0; active=1; line_start=1; frame_start=1.
- Per enabled edge (pix_en=1):
  - If h_counter == H_TOTAL-1: h_counter -> 0, and v advances (v_counter == V_TOTAL-1 -> 0, else v_counter+1).
  - Otherwise h_counter+1, and v_counter holds.
- pix_en=0: every register holds, including flags. A pulse flag therefore stays high for as long as pix_en is low.
- Horizontal state machine, decoded from h_counter:
  - H_ACT: 0..H_ACTIVE-1
  - H_FP: up to H_ACTIVE+H_FRONT-1
  - H_SY: up to +H_SYNC-1
  - H_BP: up to H_TOTAL-1, then back to H_ACT
  - h_sync is asserted exactly in H_SY: h_counter 1390..1429 with defaults.
- Vertical state machine: same structure on v_counter (V_ACT/V_FP/V_SY/V_BP). v_sync is asserted exactly for v_counter 725..729 with defaults, across full lines, changing only at h_counter == 0.
- active = H_ACT and V_ACT.
- The rising edge of v_sync (as consumed downstream) occurs once per frame, at h=0, v=725. Its period is H_TOTAL*V_TOTAL = 1,237,500 enabled cycles.
- Reset mid-frame: immediate return to reset values; no partial pulse persists.
- Counter arithmetic is 12-bit unsigned; no state beyond the terminal values is reachable.

Optional Feature:
VGA_SYNC_POS_EN
- Defined: h_sync and v_sync are active-high (720p CEA convention). Inactive level is 0, including in reset.
- Undefined: h_sync and v_sync are active-low (legacy VGA). Inactive level is 1, including in reset. Sync windows are unchanged.

Test Plan:
- Reset check: assert rst asynchronously mid-clock -> h=1649, v=749, active=0; syncs at inactive level for both macro settings.
- First frame start: release rst, one pix_en edge -> h=0, v=0, active=1, line_start=1, frame_start=1.
- Line wrap: run to h=1279 -> active=1; next edge h=1280 -> active=0. At h=1649, next edge -> h=0, v=1, line_start=1, frame_start=0.
- Sync windows: h_sync active exactly for h=1390..1429, 40 cycles per line. v_sync active exactly for v=725..729. The v_sync rising-edge spacing is 1,237,500 cycles.
- pix_en hold: hold pix_en=0 for 10 cycles at h=0, v=0 -> counters and frame_start frozen. Re-enable -> h=1, frame_start=0.
- Reset mid-frame: assert rst at v=726, h=1400 (both syncs active) -> syncs go inactive immediately. After release, the sequence restarts from 0,0.
